// File: rtl/mem_arbiter32.sv
// +----------------------------------------------------------------------+
// | mem_arbiter32 : two-port arbiter (LSU / fetch) onto one 32-bit memory |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package memory_io_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  do_read;
    logic [3:0]  do_write;
    logic [3:0]  user_tag;
  } memory_io_req32;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
    logic [3:0]  user_tag;
  } memory_io_rsp32;
endpackage

module mem_arbiter32
  import memory_io_pkg::*;
#(
  parameter int PRIORITY_MODE = 0,
  parameter int STARVE_LIMIT  = 4,
  parameter int CNT_W         = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  memory_io_req32 req0,
  output logic           req0_ready,
  output memory_io_rsp32 rsp0,
  input  memory_io_req32 req1,
  output logic           req1_ready,
  output memory_io_rsp32 rsp1,
  output memory_io_req32 mem_req,
  input  memory_io_rsp32 mem_rsp,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1,
  output logic           err_unexpected_rsp
);

  localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_LIMIT);

  logic             w_act0, w_act1, w_null0, w_null1;
  logic             w_grant0, w_grant1;
  memory_io_req32   r_mem_req;
  logic             r_own0_valid, r_own0_port;
  logic             r_own1_valid, r_own1_port;
  logic             r_last_grant;
  logic [3:0]       r_starve_cnt;
  logic [CNT_W-1:0] r_grant_cnt0, r_grant_cnt1;
  logic [1:0]       r_drain_cnt;
  logic             r_err;

  assign w_act0  = req0.valid && ((|req0.do_read) || (|req0.do_write));
  assign w_act1  = req1.valid && ((|req1.do_read) || (|req1.do_write));
  assign w_null0 = req0.valid && !w_act0;
  assign w_null1 = req1.valid && !w_act1;

  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (w_act0 && w_act1) begin
      if (PRIORITY_MODE == 0) begin
        // r_last_grant==1 means port 1 won last, so port 0 goes next
        if (r_last_grant) w_grant0 = 1'b1;
        else              w_grant1 = 1'b1;
      end else if (r_starve_cnt == c_STARVE_MAX) begin
        w_grant1 = 1'b1;
      end else begin
        w_grant0 = 1'b1;
      end
    end else if (w_act0) begin
      w_grant0 = 1'b1;
    end else if (w_act1) begin
      w_grant1 = 1'b1;
    end
  end

  // Null requests are consumed immediately without touching the memory
  assign req0_ready = reset && (w_grant0 || w_null0);
  assign req1_ready = reset && (w_grant1 || w_null1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mem_req    <= '0;
      r_own0_valid <= 1'b0;
      r_own0_port  <= 1'b0;
      r_own1_valid <= 1'b0;
      r_own1_port  <= 1'b0;
      r_last_grant <= 1'b1;
      r_starve_cnt <= 4'd0;
      r_grant_cnt0 <= '0;
      r_grant_cnt1 <= '0;
      r_drain_cnt  <= 2'd2;
      r_err        <= 1'b0;
    end else begin
      if (w_grant0) begin
        r_mem_req       <= req0;
        r_mem_req.valid <= 1'b1;
      end else if (w_grant1) begin
        r_mem_req       <= req1;
        r_mem_req.valid <= 1'b1;
      end else begin
        r_mem_req <= '0;
      end

      r_own0_valid <= w_grant0 || w_grant1;
      r_own0_port  <= w_grant1;
      r_own1_valid <= r_own0_valid;
      r_own1_port  <= r_own0_port;

      if (w_grant0 || w_grant1) r_last_grant <= w_grant1;

      if (PRIORITY_MODE == 0) begin
        r_starve_cnt <= 4'd0;
      end else if (w_grant1) begin
        r_starve_cnt <= 4'd0;
      end else if (w_act1 && (r_starve_cnt != c_STARVE_MAX)) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end

      if (w_grant0) r_grant_cnt0 <= r_grant_cnt0 + 1'b1;
      if (w_grant1) r_grant_cnt1 <= r_grant_cnt1 + 1'b1;

      // Responses still in flight from before reset are dropped silently
      if (r_drain_cnt != 2'd0) r_drain_cnt <= r_drain_cnt - 2'd1;
      if (mem_rsp.valid && !r_own1_valid && (r_drain_cnt == 2'd0)) r_err <= 1'b1;
    end
  end

  always_comb begin
    rsp0 = '0;
    rsp1 = '0;
    if (reset && r_own1_valid) begin
      if (r_own1_port) rsp1 = mem_rsp;
      else             rsp0 = mem_rsp;
    end
  end

  assign mem_req            = r_mem_req;
  assign grant_cnt0         = r_grant_cnt0;
  assign grant_cnt1         = r_grant_cnt1;
  assign err_unexpected_rsp = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter32.sv
// +----------------------------------------------------------------------+
// | tb_mem_arbiter32 : directed bench, round-robin and fixed-priority DUTs|
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mem_arbiter32;
  import memory_io_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  memory_io_req32 req0_a, req1_a, mreq_a, req0_b, req1_b, mreq_b;
  memory_io_rsp32 rsp0_a, rsp1_a, mrsp_a, model_rsp_a, inj_rsp;
  memory_io_rsp32 rsp0_b, rsp1_b, mrsp_b;
  logic rdy0_a, rdy1_a, rdy0_b, rdy1_b, err_a, err_b;
  logic [31:0] gc0_a, gc1_a, gc0_b, gc1_b;
  logic inj_en, pl_en;
  logic [31:0] pl_addr, pl_data;
  logic [31:0] mem [0:255];
  int checks = 0;
  int errors = 0;

  mem_arbiter32 #(.PRIORITY_MODE(0), .STARVE_LIMIT(4), .CNT_W(32)) dut_rr (
    .clk(clk), .reset(reset),
    .req0(req0_a), .req0_ready(rdy0_a), .rsp0(rsp0_a),
    .req1(req1_a), .req1_ready(rdy1_a), .rsp1(rsp1_a),
    .mem_req(mreq_a), .mem_rsp(mrsp_a),
    .grant_cnt0(gc0_a), .grant_cnt1(gc1_a), .err_unexpected_rsp(err_a)
  );

  mem_arbiter32 #(.PRIORITY_MODE(1), .STARVE_LIMIT(4), .CNT_W(32)) dut_fp (
    .clk(clk), .reset(reset),
    .req0(req0_b), .req0_ready(rdy0_b), .rsp0(rsp0_b),
    .req1(req1_b), .req1_ready(rdy1_b), .rsp1(rsp1_b),
    .mem_req(mreq_b), .mem_rsp(mrsp_b),
    .grant_cnt0(gc0_b), .grant_cnt1(gc1_b), .err_unexpected_rsp(err_b)
  );

  // Single-cycle byte-enabled memory behind the round-robin DUT
  always @(posedge clk) begin
    model_rsp_a <= '0;
    if (pl_en) begin
      mem[pl_addr[9:2]] <= pl_data;
    end else if (mreq_a.valid) begin
      for (int b = 0; b < 4; b++) begin
        if (mreq_a.do_write[b]) mem[mreq_a.addr[9:2]][8*b +: 8] <= mreq_a.data[8*b +: 8];
        model_rsp_a.data[8*b +: 8] <= mreq_a.do_read[b] ? mem[mreq_a.addr[9:2]][8*b +: 8] : 8'h00;
      end
      model_rsp_a.valid    <= 1'b1;
      model_rsp_a.user_tag <= mreq_a.user_tag;
    end
  end
  assign mrsp_a = inj_en ? inj_rsp : model_rsp_a;

  // Echo responder behind the fixed-priority DUT
  always @(posedge clk) begin
    mrsp_b <= '0;
    if (mreq_b.valid) begin
      mrsp_b.valid    <= 1'b1;
      mrsp_b.data     <= mreq_b.addr;
      mrsp_b.user_tag <= mreq_b.user_tag;
    end
  end

  function automatic memory_io_req32 mk(input logic [31:0] addr, input logic [31:0] data,
                                        input logic [3:0] rd, input logic [3:0] wr,
                                        input logic [3:0] tag);
    memory_io_req32 r;
    r.valid = 1'b1; r.addr = addr; r.data = data;
    r.do_read = rd; r.do_write = wr; r.user_tag = tag;
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_a = '0; req1_a = '0; req0_b = '0; req1_b = '0;
    inj_en = 1'b0; inj_rsp = '0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    cyc(); cyc();
    reset = 1'b1;
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    pl_en = 1'b1; pl_addr = addr; pl_data = data;
    cyc();
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    req0_a = mk(32'h40, 32'h0, 4'hF, 4'h0, 4'h1);
    req1_a = mk(32'h44, 32'h0, 4'hF, 4'h0, 4'h2);
    req0_b = mk(32'h48, 32'h0, 4'hF, 4'h0, 4'h3);
    cyc(); cyc();
    @(negedge clk);
    checks++; if (rdy0_a !== 1'b0) begin errors++; $display("FAIL reset_rdy0 got %b exp 0", rdy0_a); end
    checks++; if (rdy1_a !== 1'b0) begin errors++; $display("FAIL reset_rdy1 got %b exp 0", rdy1_a); end
    checks++; if (rdy0_b !== 1'b0) begin errors++; $display("FAIL reset_rdy0_fp got %b exp 0", rdy0_b); end
    checks++; if (mreq_a !== '0) begin errors++; $display("FAIL reset_mem_req got %h exp 0", mreq_a); end
    checks++; if (rsp0_a !== '0 || rsp1_a !== '0) begin errors++; $display("FAIL reset_rsp got %h/%h exp 0", rsp0_a, rsp1_a); end
    checks++; if (gc0_a !== 32'd0 || gc1_a !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d/%0d exp 0", gc0_a, gc1_a); end
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_a); end
    cyc();
    idle_inputs();
    reset = 1'b1;
    cyc(); cyc(); cyc();
  endtask

  task automatic test_single_read();
    preload(32'h40, 32'h11223344);
    req0_a = mk(32'h40, 32'h0, 4'hF, 4'h0, 4'h5);
    @(negedge clk);
    checks++; if (rdy0_a !== 1'b1) begin errors++; $display("FAIL sr_ready got %b exp 1", rdy0_a); end
    cyc();
    req0_a = '0;
    @(negedge clk);
    checks++; if (mreq_a.valid !== 1'b1 || mreq_a.addr !== 32'h40 || mreq_a.user_tag !== 4'h5) begin
      errors++; $display("FAIL sr_mem_req got %h exp valid addr 40 tag 5", mreq_a); end
    cyc();
    @(negedge clk);
    checks++; if (rsp0_a.valid !== 1'b1 || rsp0_a.data !== 32'h11223344 || rsp0_a.user_tag !== 4'h5) begin
      errors++; $display("FAIL sr_rsp0 got %h exp valid data 11223344 tag 5", rsp0_a); end
    checks++; if (rsp1_a !== '0) begin errors++; $display("FAIL sr_rsp1 got %h exp 0", rsp1_a); end
    checks++; if (gc0_a !== 32'd1) begin errors++; $display("FAIL sr_cnt0 got %0d exp 1", gc0_a); end
    cyc();
  endtask

  task automatic test_round_robin();
    logic [3:0] etag;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      if (c < 6) begin
        req0_a = mk(32'h40, 32'h0, 4'hF, 4'h0, 4'((c + 1) / 2));
        req1_a = mk(32'h40, 32'h0, 4'hF, 4'h0, 4'(8 + c / 2));
      end else begin
        req0_a = '0; req1_a = '0;
      end
      @(negedge clk);
      if (c < 6) begin
        checks++;
        if (rdy0_a !== (c % 2 == 0) || rdy1_a !== (c % 2 == 1)) begin
          errors++; $display("FAIL rr_grant c=%0d got %b%b exp port %0d", c, rdy0_a, rdy1_a, c % 2); end
      end
      if (c >= 2) begin
        etag = ((c - 2) % 2 == 0) ? 4'((c - 2) / 2) : 4'(8 + (c - 2) / 2);
        checks++;
        if ((c - 2) % 2 == 0) begin
          if (rsp0_a.valid !== 1'b1 || rsp0_a.user_tag !== etag || rsp0_a.data !== 32'h11223344 || rsp1_a.valid !== 1'b0) begin
            errors++; $display("FAIL rr_rsp0 c=%0d got %h/%h exp tag %h on port 0", c, rsp0_a, rsp1_a, etag); end
        end else begin
          if (rsp1_a.valid !== 1'b1 || rsp1_a.user_tag !== etag || rsp1_a.data !== 32'h11223344 || rsp0_a.valid !== 1'b0) begin
            errors++; $display("FAIL rr_rsp1 c=%0d got %h/%h exp tag %h on port 1", c, rsp0_a, rsp1_a, etag); end
        end
      end
      cyc();
    end
    checks++; if (gc0_a !== 32'd3 || gc1_a !== 32'd3) begin errors++; $display("FAIL rr_cnt got %0d/%0d exp 3/3", gc0_a, gc1_a); end
  endtask

  task automatic test_starvation();
    logic exp1;
    for (int c = 0; c < 10; c++) begin
      req0_b = mk(32'h100, 32'h0, 4'hF, 4'h0, 4'h1);
      req1_b = mk(32'h200, 32'h0, 4'hF, 4'h0, 4'h2);
      exp1 = (c % 5 == 4);
      @(negedge clk);
      checks++;
      if (rdy1_b !== exp1 || rdy0_b !== !exp1) begin
        errors++; $display("FAIL starve_grant c=%0d got %b%b exp port %0d", c, rdy0_b, rdy1_b, exp1); end
      cyc();
    end
    req0_b = '0; req1_b = '0;
    @(negedge clk);
    checks++; if (gc0_b !== 32'd8 || gc1_b !== 32'd2) begin errors++; $display("FAIL starve_cnt got %0d/%0d exp 8/2", gc0_b, gc1_b); end
    cyc(); cyc(); cyc();
  endtask

  task automatic test_byte_write();
    preload(32'h80, 32'h00000000);
    req0_a = mk(32'h80, 32'hAABBCCDD, 4'h0, 4'b0101, 4'h3);
    @(negedge clk);
    checks++; if (rdy0_a !== 1'b1) begin errors++; $display("FAIL bw_wr_ready got %b exp 1", rdy0_a); end
    cyc();
    req0_a = mk(32'h80, 32'h0, 4'hF, 4'h0, 4'h4);
    @(negedge clk);
    checks++; if (rdy0_a !== 1'b1) begin errors++; $display("FAIL bw_rd_ready got %b exp 1", rdy0_a); end
    cyc();
    req0_a = '0;
    @(negedge clk);
    checks++; if (rsp0_a.valid !== 1'b1 || rsp0_a.user_tag !== 4'h3) begin errors++; $display("FAIL bw_wr_rsp got %h exp valid tag 3", rsp0_a); end
    cyc();
    @(negedge clk);
    checks++; if (rsp0_a.valid !== 1'b1 || rsp0_a.data !== 32'h00BB00DD || rsp0_a.user_tag !== 4'h4) begin
      errors++; $display("FAIL bw_rd_rsp got %h exp valid data 00bb00dd tag 4", rsp0_a); end
    cyc();
    @(negedge clk);
    checks++; if (rsp0_a.valid !== 1'b0 || rsp1_a.valid !== 1'b0) begin errors++; $display("FAIL bw_extra_rsp got %b%b exp 00", rsp0_a.valid, rsp1_a.valid); end
    cyc();
  endtask

  task automatic test_null();
    logic [31:0] saved1;
    saved1 = gc1_a;
    req1_a = mk(32'h40, 32'h0, 4'h0, 4'h0, 4'h6);
    @(negedge clk);
    checks++; if (rdy1_a !== 1'b1 || rdy0_a !== 1'b0) begin errors++; $display("FAIL null_ready got %b%b exp 01", rdy0_a, rdy1_a); end
    cyc();
    req1_a = '0;
    @(negedge clk);
    checks++; if (mreq_a.valid !== 1'b0) begin errors++; $display("FAIL null_mem_req got %b exp 0", mreq_a.valid); end
    checks++; if (gc1_a !== saved1) begin errors++; $display("FAIL null_cnt1 got %0d exp %0d", gc1_a, saved1); end
    cyc();
    @(negedge clk);
    checks++; if (rsp1_a.valid !== 1'b0 || rsp0_a.valid !== 1'b0) begin errors++; $display("FAIL null_rsp got %b%b exp 00", rsp0_a.valid, rsp1_a.valid); end
    cyc();
  endtask

  task automatic test_reset_midflight();
    req0_a = mk(32'h40, 32'h0, 4'hF, 4'h0, 4'h7);
    @(negedge clk);
    checks++; if (rdy0_a !== 1'b1) begin errors++; $display("FAIL mf_ready got %b exp 1", rdy0_a); end
    cyc();
    req0_a = '0;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (rsp0_a !== '0 || rsp1_a !== '0) begin errors++; $display("FAIL mf_rsp_in_reset got %h/%h exp 0", rsp0_a, rsp1_a); end
    cyc();
    reset = 1'b1;
    @(negedge clk);
    checks++; if (rsp0_a !== '0 || rsp1_a !== '0) begin errors++; $display("FAIL mf_rsp_after got %h/%h exp 0", rsp0_a, rsp1_a); end
    cyc(); cyc(); cyc();
    @(negedge clk);
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL mf_err got %b exp 0", err_a); end
    cyc();
  endtask

  task automatic test_unexpected();
    inj_rsp = '0;
    inj_rsp.valid = 1'b1;
    inj_rsp.data = 32'hDEADBEEF;
    inj_en = 1'b1;
    @(negedge clk);
    checks++; if (rsp0_a.valid !== 1'b0 || rsp1_a.valid !== 1'b0) begin errors++; $display("FAIL ux_drop got %b%b exp 00", rsp0_a.valid, rsp1_a.valid); end
    cyc();
    inj_en = 1'b0;
    @(negedge clk);
    checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL ux_err_set got %b exp 1", err_a); end
    cyc(); cyc(); cyc();
    @(negedge clk);
    checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL ux_err_hold got %b exp 1", err_a); end
    cyc();
    do_reset();
    @(negedge clk);
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL ux_err_clear got %b exp 0", err_a); end
    cyc();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    #1;
    test_reset();
    test_single_read();
    test_round_robin();
    test_starvation();
    test_byte_write();
    test_null();
    test_reset_midflight();
    test_unexpected();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
